// File: rtl/lcv_mul_seq_pkg.sv
// Shared types and constants for the sequential WIDTHxWIDTH multiplier.
// The multiplier builds its product from four half-width partial products.
package lcv_mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int PP_IDX_W = 2;

    typedef logic [PP_IDX_W-1:0] pp_idx_t;

    localparam pp_idx_t PP_FIRST = 2'd0;
    localparam pp_idx_t PP_LAST  = 2'd3;

    // Partial products are issued as lo*lo, lo*hi, hi*lo, hi*hi.
    // Their weights are 2^0, 2^H, 2^H and 2^(2H).
    function automatic int pp_shift(pp_idx_t idx, int h);
        int sh;
        sh = 0;
        case (idx)
            2'd0:    sh = 0;
            2'd1:    sh = h;
            2'd2:    sh = h;
            default: sh = 2 * h;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/lcv_mul_seq_if.sv
// Operand/product handshake bundle for lcv_mul_seq.
// The master offers operands and takes products; the slave is the multiplier.
interface lcv_mul_seq_if #(
    parameter int WIDTH = 32
);

    logic                 inp_valid;
    logic                 inp_ready;
    logic [WIDTH-1:0]     inp_a;
    logic [WIDTH-1:0]     inp_b;
    logic                 outp_valid;
    logic                 outp_ready;
    logic [2*WIDTH-1:0]   outp_data;

    modport master (
        output inp_valid,
        output inp_a,
        output inp_b,
        output outp_ready,
        input  inp_ready,
        input  outp_valid,
        input  outp_data
    );

    modport slave (
        input  inp_valid,
        input  inp_a,
        input  inp_b,
        input  outp_ready,
        output inp_ready,
        output outp_valid,
        output outp_data
    );

endinterface

// File: rtl/lcv_umul_del1.sv
// Registered unsigned HxH -> 2H multiplier with one cycle of latency.
// Kept as a bare multiply-plus-register so synthesis maps it onto a DSP slice.
module lcv_umul_del1 #(
    parameter int H = 16
) (
    input  logic           clk,
    input  logic [H-1:0]   a_i,
    input  logic [H-1:0]   b_i,
    output logic [2*H-1:0] p_o
);

    (* use_dsp = "yes" *) logic [2*H-1:0] p_q;

    // NOTE: this pipeline register is deliberately left without reset; a reset
    // would keep it out of the DSP's internal register, and downstream logic
    // only consumes it when a separately reset valid tag says so.
    always_ff @(posedge clk) begin
        p_q <= {{H{1'b0}}, a_i} * {{H{1'b0}}, b_i};
    end

    assign p_o = p_q;

endmodule

// File: rtl/lcv_mul_seq.sv
// Sequential unsigned WIDTHxWIDTH multiplier: four half-width partial products
// pass through one registered multiplier and are shift-accumulated into 2*WIDTH bits.
module lcv_mul_seq
    import lcv_mul_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    lcv_mul_seq_if.slave bus
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    state_e           state_q, state_d;
    pp_idx_t          idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic             pp_vld_q, pp_vld_d;
    pp_idx_t          pp_tag_q, pp_tag_d;

    logic [H-1:0]     mul_a;
    logic [H-1:0]     mul_b;
    logic [WIDTH-1:0] mul_p;
    logic [PW-1:0]    pp_aligned;
    logic             accept;
    logic             release_out;

    assign accept      = bus.inp_valid  && (state_q == IDLE);
    assign release_out = bus.outp_ready && (state_q == DONE);

    // Select the halves for the partial product currently being issued.
    always_comb begin
        mul_a = a_q[H-1:0];
        mul_b = b_q[H-1:0];
        case (idx_q)
            2'd1: begin
                mul_b = b_q[WIDTH-1:H];
            end
            2'd2: begin
                mul_a = a_q[WIDTH-1:H];
            end
            2'd3: begin
                mul_a = a_q[WIDTH-1:H];
                mul_b = b_q[WIDTH-1:H];
            end
            default: begin
                mul_a = a_q[H-1:0];
                mul_b = b_q[H-1:0];
            end
        endcase
    end

    lcv_umul_del1 #(
        .H (H)
    ) u_umul (
        .clk (clk),
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    // The product register lags the issue index by one cycle, so the weight
    // travels alongside it in pp_tag_q.
    assign pp_aligned = {{WIDTH{1'b0}}, mul_p} << pp_shift(pp_tag_q, H);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        pp_vld_d = (state_q == ISSUE);
        pp_tag_d = idx_q;

        if (pp_vld_q) begin
            acc_d = acc_q + pp_aligned;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    a_d     = bus.inp_a;
                    b_d     = bus.inp_b;
                    acc_d   = '0;
                    idx_d   = PP_FIRST;
                end
            end
            ISSUE: begin
                idx_d = idx_q + pp_idx_t'(1);
                if (idx_q == PP_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (release_out) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= PP_FIRST;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            pp_vld_q <= 1'b0;
            pp_tag_q <= PP_FIRST;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            pp_vld_q <= pp_vld_d;
            pp_tag_q <= pp_tag_d;
        end
    end

    assign bus.inp_ready  = (state_q == IDLE);
    assign bus.outp_valid = (state_q == DONE);
    assign bus.outp_data  = acc_q;

endmodule

// File: tb/tb_lcv_mul_seq.sv
// Self-checking bench for lcv_mul_seq (WIDTH=32): directed vectors, handshake
// corner cases, mid-operation reset and a randomized back-to-back run.
module tb_lcv_mul_seq;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lcv_mul_seq_if #(.WIDTH(W)) bus ();

    lcv_mul_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return '1;
        if (sel == 1) return '0;
        return $urandom;
    endfunction

    // Waits (bounded) for inp_ready, offers one pair, returns just after the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
        int waited;
        waited = 0;
        while (!bus.inp_ready && waited < 20) begin
            step();
            waited++;
        end
        check("ready_before_accept", 64'(bus.inp_ready), 64'd1);
        bus.inp_a     = a;
        bus.inp_b     = b;
        bus.inp_valid = 1'b1;
        step();
        bus.inp_valid = 1'b0;
        if (scramble) begin
            bus.inp_a = $urandom;
            bus.inp_b = $urandom;
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.outp_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int spurious;
        logic [2*W-1:0] exp;

        bus.inp_valid  = 1'b0;
        bus.inp_a      = '0;
        bus.inp_b      = '0;
        bus.outp_ready = 1'b0;
        rst            = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        check("reset_inp_ready",  64'(bus.inp_ready),  64'd1);
        check("reset_outp_valid", 64'(bus.outp_valid), 64'd0);
        check("reset_outp_data",  bus.outp_data,       64'd0);

        // Directed vectors with their known products.
        vecs[0] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{a: 32'h0000_FFFF, b: 32'h0001_0001, exp: 64'h0000_0000_FFFF_FFFF};
        vecs[2] = '{a: 32'h0001_0000, b: 32'h0001_0000, exp: 64'h0000_0001_0000_0000};
        vecs[3] = '{a: 32'h0000_0000, b: 32'hDEAD_BEEF, exp: 64'h0};

        bus.outp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_op(vecs[i].a, vecs[i].b, 1'b0);
            wait_valid(lat);
            check("vec_latency", 64'(lat), 64'd5);
            check("vec_data", bus.outp_data, vecs[i].exp);
            step();
            check("vec_valid_drop", 64'(bus.outp_valid), 64'd0);
            check("vec_ready_back", 64'(bus.inp_ready),  64'd1);
        end

        // Operands change right after accept; the latched pair must win.
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        wait_valid(lat);
        check("latch_latency", 64'(lat), 64'd5);
        check("latch_data", bus.outp_data, ref_mul(32'h1234_5678, 32'h9ABC_DEF0));
        step();

        // Back-pressure in DONE with ignored inp_valid pulses, then a one-cycle release.
        bus.outp_ready = 1'b0;
        exp = ref_mul(32'hCAFE_BABE, 32'h0BAD_F00D);
        start_op(32'hCAFE_BABE, 32'h0BAD_F00D, 1'b0);
        wait_valid(lat);
        check("hold_latency", 64'(lat), 64'd5);
        for (int i = 0; i < 10; i++) begin
            bus.inp_valid = i[0];
            bus.inp_a     = $urandom;
            bus.inp_b     = $urandom;
            step();
            check("hold_data",  bus.outp_data,        exp);
            check("hold_valid", 64'(bus.outp_valid),  64'd1);
            check("hold_ready", 64'(bus.inp_ready),   64'd0);
        end
        bus.inp_valid  = 1'b0;
        bus.outp_ready = 1'b1;
        step();
        bus.outp_ready = 1'b0;
        check("release_valid_drop", 64'(bus.outp_valid), 64'd0);
        check("release_ready",      64'(bus.inp_ready),  64'd1);
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.outp_valid || !bus.inp_ready) spurious++;
        end
        check("release_single_transfer", 64'(spurious), 64'd0);

        // Reset at T0+3 discards the operation in flight.
        bus.outp_ready = 1'b1;
        start_op(32'h0000_1234, 32'h0000_5678, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_outp_valid", 64'(bus.outp_valid), 64'd0);
        check("midrst_outp_data",  bus.outp_data,       64'd0);
        check("midrst_inp_ready",  64'(bus.inp_ready),  64'd1);
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.outp_valid) spurious++;
        end
        check("midrst_no_output", 64'(spurious), 64'd0);
        start_op(32'd3, 32'd5, 1'b0);
        wait_valid(lat);
        check("after_rst_latency", 64'(lat), 64'd5);
        check("after_rst_data", bus.outp_data, 64'd15);
        step();

        // Back-to-back random traffic against the arithmetic model.
        begin
            logic [2*W-1:0] exp_q [$];
            int  cyc;
            int  last_acc;
            int  n_acc;
            int  got;
            bit  will_acc;

            cyc      = 0;
            last_acc = -1;
            n_acc    = 0;
            got      = 0;
            bus.outp_ready = 1'b1;
            bus.inp_a      = rand_operand();
            bus.inp_b      = rand_operand();
            bus.inp_valid  = 1'b1;
            while (got < 100 && cyc < 1000) begin
                will_acc = bus.inp_ready && bus.inp_valid;
                step();
                cyc++;
                if (will_acc) begin
                    exp_q.push_back(ref_mul(bus.inp_a, bus.inp_b));
                    if (last_acc >= 0) check("b2b_interval", 64'(cyc - last_acc), 64'd7);
                    last_acc = cyc;
                    n_acc++;
                    if (n_acc < 100) begin
                        bus.inp_a = rand_operand();
                        bus.inp_b = rand_operand();
                    end else begin
                        bus.inp_valid = 1'b0;
                    end
                end
                if (bus.outp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("b2b_unexpected_output", 64'd1, 64'd0);
                    end else begin
                        check("b2b_data", bus.outp_data, exp_q.pop_front());
                    end
                    got++;
                end
            end
            bus.inp_valid = 1'b0;
            check("b2b_result_count", 64'(got), 64'd100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcv_mul_seq.md
LCV_MUL_SEQ -- requirements
Module: lcv_mul_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; SHALL be even and >= 4; H = WIDTH/2.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 inp_valid  input  1  operand pair offered.
REQ-005 inp_ready  output  1  block can accept an operand pair.
REQ-006 inp_a  input  WIDTH  unsigned multiplicand.
REQ-007 inp_b  input  WIDTH  unsigned multiplier.
REQ-008 outp_valid  output  1  product available.
REQ-009 outp_ready  input  1  consumer takes product.
REQ-010 outp_data  output  2*WIDTH  unsigned product inp_a*inp_b.

Function
REQ-011 Operation: unsigned WIDTHxWIDTH multiply built from four HxH partial products through one registered HxH multiplier; result exact, 2*WIDTH bits, no truncation or overflow.
REQ-012 States: IDLE, ISSUE, DRAIN, DONE.
REQ-013 inp_ready SHALL equal (state == IDLE); no combinational path from inp_valid or outp_ready to inp_ready.
REQ-014 Accept: the edge where inp_valid && inp_ready (edge T0) latches inp_a/inp_b, clears the accumulator, and moves IDLE->ISSUE.
REQ-015 ISSUE: during cycles T0+1..T0+4, partial product k = 0..3 is presented to the multiplier in the order a_lo*b_lo, a_lo*b_hi, a_hi*b_lo, a_hi*b_hi, tracked by a 2-bit index.
REQ-016 Multiplier latency is 1 cycle: product k is registered at edge T0+1+k and added into the accumulator at edge T0+2+k, shifted left by 0, H, H and WIDTH bits respectively.
REQ-017 ISSUE->DRAIN at edge T0+4 (index wraps 3->0); DRAIN->DONE at edge T0+5, by which point the last accumulate is complete.
REQ-018 outp_valid SHALL be high exactly from edge T0+5 (5 cycles after accept) while state == DONE; outp_data is driven from the accumulator register.
REQ-019 In DONE, outp_data and outp_valid SHALL stay stable until an edge with outp_ready high; that edge moves DONE->IDLE, and outp_valid drops.
REQ-020 The earliest next accept is the edge after the DONE->IDLE edge, giving a minimum initiation interval of 7 cycles; no overlap of operations.
REQ-021 inp_valid in non-IDLE states is ignored; inp_a/inp_b changes after accept SHALL NOT affect the result.
REQ-022 outp_ready outside DONE is ignored.
REQ-023 Accumulator SHALL be 2*WIDTH bits; intermediate sums never exceed 2*WIDTH bits.

Reset
REQ-024 rst at any edge SHALL force state IDLE, index 0, accumulator 0, outp_valid 0, outp_data 0, and inp_ready 1 from the following cycle, discarding any in-flight operation.
REQ-025 rst SHALL dominate a simultaneous accept or output handshake on the same edge.
REQ-026 The multiplier pipeline register need not be reset, but its content SHALL never reach outp_data after reset without a new accept.

Structure
REQ-027 Shared package lcv_mul_seq_pkg SHALL hold the state enum typedef (IDLE, ISSUE, DRAIN, DONE) and the partial-product index width/shift constants.
REQ-028 Sub-module lcv_umul_del1 (parameter H): registered unsigned HxH -> 2H multiply with 1-cycle latency, marked for DSP inference; exactly one instance.
REQ-029 The rest of the block (FSM, operand muxing, shift-accumulate) SHALL stay in lcv_mul_seq.

Verification (WIDTH=32)
REQ-030 Test 1: a=0xFFFFFFFF, b=0xFFFFFFFF accepted at T0, outp_ready=1 -> outp_valid first high at T0+5 with outp_data=0xFFFFFFFE00000001.
REQ-031 Test 2: a=0x0000FFFF, b=0x00010001 -> 0x00000000FFFFFFFF; a=0x00010000, b=0x00010000 -> 0x0000000100000000; a=0, b=0xDEADBEEF -> 0.
REQ-032 Test 3: outp_ready held low for 10 cycles in DONE -> outp_data is stable, inp_ready stays 0, and inp_valid pulses are ignored; a single outp_ready pulse yields exactly one transfer.
REQ-033 Test 4: rst asserted at T0+3 mid-operation -> outp_valid stays 0, outp_data=0 and inp_ready=1 the next cycle; a subsequent 3*5 operation returns 15.
REQ-034 Test 5: back-to-back, with inp_valid and outp_ready held high over 100 random operand pairs -> every result matches the reference model and accept edges are exactly 7 cycles apart.
REQ-035 Test 6: operands are changed on the cycle after accept -> the result reflects the latched values.
